// File: rtl/dice_game_fsm.sv
// Craps rules controller: captures the dice sum on roll-button release and
// tracks first roll / point / win / lose. Define ROLL_COUNT_EN to add roll_count.
module dice_game_fsm #(
   parameter int SUM_W   = 4,
   parameter int MIN_SUM = 2,
   parameter int MAX_SUM = 12,
   parameter int CNT_W   = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             roll,
   input  logic [SUM_W-1:0] sum,
   input  logic             new_game,
   output logic             win,
   output logic             lose,
   output logic [SUM_W-1:0] point,
   output logic             point_valid,
   output logic             roll_done,
`ifdef ROLL_COUNT_EN
   output logic [CNT_W-1:0] roll_count,
`endif
   output logic             err
);

   // state    | meaning
   // ST_FIRST | waiting for the come-out roll
   // ST_POINT | point established, rolling for point or seven
   // ST_WIN   | natural or point made; holds until new_game/reset
   // ST_LOSE  | craps or seven-out; holds until new_game/reset
   typedef enum logic [1:0] {ST_FIRST, ST_POINT, ST_WIN, ST_LOSE} state_t;

   localparam logic [SUM_W-1:0] SUM_MIN = SUM_W'(MIN_SUM);
   localparam logic [SUM_W-1:0] SUM_MAX = SUM_W'(MAX_SUM);
   localparam logic [SUM_W-1:0] S2  = SUM_W'(2);
   localparam logic [SUM_W-1:0] S3  = SUM_W'(3);
   localparam logic [SUM_W-1:0] S7  = SUM_W'(7);
   localparam logic [SUM_W-1:0] S11 = SUM_W'(11);
   localparam logic [SUM_W-1:0] S12 = SUM_W'(12);

   state_t           state_q, state_d;
   logic             roll_q;
   logic             win_q, win_d;
   logic             lose_q, lose_d;
   logic [SUM_W-1:0] point_q, point_d;
   logic             point_valid_q, point_valid_d;
   logic             roll_done_q, roll_done_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic release_ev;
   logic legal;
   logic accepted;

   assign release_ev = roll_q & ~roll;
   assign legal      = (sum >= SUM_MIN) && (sum <= SUM_MAX);

   always_comb begin
      state_d     = state_q;
      point_d     = point_q;
      cnt_d       = cnt_q;
      roll_done_d = 1'b0;
      err_d       = 1'b0;
      accepted    = 1'b0;

      // new_game takes priority over any release on the same edge
      if (new_game) begin
         state_d = ST_FIRST;
         point_d = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_FIRST, ST_POINT: begin
               if (release_ev) begin
                  if (!legal) begin
                     err_d = 1'b1;
                  end else begin
                     accepted    = 1'b1;
                     roll_done_d = 1'b1;
                     if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                  end
               end
            end
            ST_WIN, ST_LOSE: ;
            default: begin
               state_d = ST_FIRST;
               point_d = '0;
            end
         endcase

         if (accepted) begin
            if (state_q == ST_FIRST) begin
               if (sum == S7 || sum == S11) begin
                  state_d = ST_WIN;
               end else if (sum == S2 || sum == S3 || sum == S12) begin
                  state_d = ST_LOSE;
               end else begin
                  state_d = ST_POINT;
                  point_d = sum;
               end
            end else if (sum == point_q) begin
               state_d = ST_WIN;
            end else if (sum == S7) begin
               state_d = ST_LOSE;
            end
         end
      end

      win_d         = (state_d == ST_WIN);
      lose_d        = (state_d == ST_LOSE);
      point_valid_d = (state_d == ST_POINT);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= ST_FIRST;
         roll_q        <= 1'b0;
         win_q         <= 1'b0;
         lose_q        <= 1'b0;
         point_q       <= '0;
         point_valid_q <= 1'b0;
         roll_done_q   <= 1'b0;
         err_q         <= 1'b0;
         cnt_q         <= '0;
      end else begin
         state_q       <= state_d;
         roll_q        <= roll;
         win_q         <= win_d;
         lose_q        <= lose_d;
         point_q       <= point_d;
         point_valid_q <= point_valid_d;
         roll_done_q   <= roll_done_d;
         err_q         <= err_d;
         cnt_q         <= cnt_d;
      end
   end

   assign win         = win_q;
   assign lose        = lose_q;
   assign point       = point_q;
   assign point_valid = point_valid_q;
   assign roll_done   = roll_done_q;
   assign err         = err_q;

`ifdef ROLL_COUNT_EN
   assign roll_count = cnt_q;
`else
   // without the feature the counter has no load and is trimmed away
   logic [CNT_W-1:0] unused_cnt;
   assign unused_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_dice_game_fsm.sv
// Scoreboard bench for dice_game_fsm: directed craps scenarios plus random
// roll/release traffic, checked against a rules-level model every cycle.
module tb_dice_game_fsm;

   localparam int SUM_W = 4;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             roll = 1'b0;
   logic [SUM_W-1:0] sum = '0;
   logic             new_game = 1'b0;
   logic             win, lose, point_valid, roll_done, err;
   logic [SUM_W-1:0] point;
`ifdef ROLL_COUNT_EN
   logic [CNT_W-1:0] roll_count;
`endif

   dice_game_fsm #(.SUM_W(SUM_W), .MIN_SUM(2), .MAX_SUM(12), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .roll(roll), .sum(sum), .new_game(new_game),
      .win(win), .lose(lose), .point(point), .point_valid(point_valid),
      .roll_done(roll_done),
`ifdef ROLL_COUNT_EN
      .roll_count(roll_count),
`endif
      .err(err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic             win;
      logic             lose;
      logic [SUM_W-1:0] point;
      logic             point_valid;
      logic             roll_done;
      logic             err;
      logic [CNT_W-1:0] count;
   } exp_t;

   exp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;

   // game model: 0 come-out, 1 point, 2 won, 3 lost
   int m_game = 0;
   int m_prev_roll = 0;
   int m_point = 0;
   int m_count = 0;

   task automatic step(input logic r, input logic rl, input int s, input logic ng);
      exp_t e;
      int   done, bad;
      @(negedge clk);
      reset = r; roll = rl; sum = SUM_W'(s); new_game = ng;
      done = 0; bad = 0;
      if (!r) begin
         m_game = 0; m_prev_roll = 0; m_point = 0; m_count = 0;
      end else begin
         if (ng) begin
            m_game = 0; m_point = 0; m_count = 0;
         end else if (m_prev_roll == 1 && rl == 1'b0 && m_game < 2) begin
            if (s < 2 || s > 12) begin
               bad = 1;
            end else begin
               done = 1;
               if (m_count < (1 << CNT_W) - 1) m_count++;
               if (m_game == 0) begin
                  if (s == 7 || s == 11) m_game = 2;
                  else if (s == 2 || s == 3 || s == 12) m_game = 3;
                  else begin m_game = 1; m_point = s; end
               end else if (s == m_point) m_game = 2;
               else if (s == 7) m_game = 3;
            end
         end
         m_prev_roll = int'(rl);
      end
      e.win         = (m_game == 2);
      e.lose        = (m_game == 3);
      e.point       = SUM_W'(m_point);
      e.point_valid = (m_game == 1);
      e.roll_done   = (done == 1);
      e.err         = (bad == 1);
      e.count       = CNT_W'(m_count);
      exp_q.push_back(e);
   endtask

   task automatic do_roll(input int s);
      step(1'b1, 1'b1, (s + 5) % 16, 1'b0);
      step(1'b1, 1'b0, s, 1'b0);
   endtask

   always @(posedge clk) begin
      exp_t a, e;
      #1;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         a.win = win; a.lose = lose; a.point = point; a.point_valid = point_valid;
         a.roll_done = roll_done; a.err = err;
`ifdef ROLL_COUNT_EN
         a.count = roll_count;
`else
         a.count = e.count;
`endif
         vectors++;
         if (a !== e) begin
            miscompares++;
            $display("FAIL outputs @%0t: got win=%b lose=%b point=%0d pv=%b done=%b err=%b cnt=%0d, want win=%b lose=%b point=%0d pv=%b done=%b err=%b cnt=%0d",
               $time, a.win, a.lose, a.point, a.point_valid, a.roll_done, a.err, a.count,
               e.win, e.lose, e.point, e.point_valid, e.roll_done, e.err, e.count);
         end
      end
   end

   initial begin
      // 1: natural seven
      step(1'b0, 1'b0, 0, 1'b0);
      step(1'b0, 1'b0, 0, 1'b0);
      do_roll(7);
      step(1'b1, 1'b0, 7, 1'b0);
      step(1'b1, 1'b0, 0, 1'b1);
      // 2: craps on 12, later release ignored
      do_roll(12);
      do_roll(8);
      do_roll(1);
      step(1'b1, 1'b0, 0, 1'b1);
      // 3: point 5, misses, then made
      do_roll(5); do_roll(9); do_roll(4); do_roll(5);
      step(1'b1, 1'b0, 0, 1'b0);
      step(1'b1, 1'b0, 0, 1'b1);
      // 4: point 10, seven-out, new_game
      do_roll(10); do_roll(7);
      step(1'b1, 1'b0, 0, 1'b1);
      step(1'b1, 1'b0, 0, 1'b0);
      // 5: illegal sums, then new_game coincident with release
      do_roll(1); do_roll(13); do_roll(0); do_roll(15);
      step(1'b1, 1'b1, 7, 1'b0);
      step(1'b1, 1'b0, 7, 1'b1);
      step(1'b1, 1'b1, 7, 1'b1);
      step(1'b1, 1'b0, 7, 1'b1);
      step(1'b1, 1'b0, 7, 1'b0);
      // 6: reset mid-point with roll held high
      do_roll(6);
      step(1'b1, 1'b1, 6, 1'b0);
      step(1'b0, 1'b0, 6, 1'b0);
      step(1'b1, 1'b1, 6, 1'b0);
      step(1'b1, 1'b0, 6, 1'b0);
      step(1'b1, 1'b0, 6, 1'b0);
      // long point game then random traffic
      step(1'b1, 1'b0, 0, 1'b1);
      do_roll(8);
      for (int i = 0; i < 20; i++) do_roll((i % 2) ? 4 : 9);
      do_roll(8);
      for (int i = 0; i < 3000; i++) begin
         int s;
         s = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(2, 12);
         step(($urandom_range(0, 199) != 0), $urandom_range(0, 1) == 1, s,
              ($urandom_range(0, 39) == 0));
      end
      step(1'b1, 1'b0, 0, 1'b0);
      repeat (3) @(negedge clk);
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
